// File: rtl/bitonic_sort_pipe_pkg.sv
// Shared helpers for the bitonic sorting network: stage count and the mapping
// from a linear layer index to its (phase, layer) coordinates and pair direction.
package sort_pkg;

    // Largest element-count exponent the network is built for.
    localparam int unsigned MAX_LOG_N = 6;

    // Number of registered compare-exchange layers for 2**log_n elements.
    function automatic int unsigned num_stages(input int unsigned log_n);
        return (log_n * (log_n + 1)) / 2;
    endfunction

    // Phase p of linear layer k: the largest p with num_stages(p) <= k.
    function automatic int unsigned stage_p(input int unsigned k);
        int unsigned p;
        p = 0;
        for (int unsigned j = 1; j <= MAX_LOG_N; j++) begin
            if (num_stages(j) <= k) begin
                p = j;
            end
        end
        return p;
    endfunction

    // Layer q of linear layer k: counts down from p to 0 within the phase.
    function automatic int unsigned stage_q(input int unsigned k);
        int unsigned p;
        p = stage_p(k);
        return p - (k - num_stages(p));
    endfunction

    // Ascending pair when bit (p+1) of the lower index is clear. In the last
    // phase that bit lies above the index range, so every pair is ascending.
    function automatic logic pair_asc(input int unsigned i, input int unsigned p);
        return ((i >> (p + 1)) & 1) == 0;
    endfunction

endpackage

// File: rtl/bitonic_sort_pipe_layer.sv
// One registered compare-exchange layer (p,q) of the bitonic network, plus
// the two-input max/min comparator it is built from.
module max_min #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] max_v,
    output logic [WIDTH-1:0] min_v
);

    // Unsigned compare; on a tie the inputs pass straight through.
    always_comb begin
        if (a >= b) begin
            max_v = a;
            min_v = b;
        end else begin
            max_v = b;
            min_v = a;
        end
    end

endmodule

module bitonic_layer
    import sort_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int LOG_N = 3,
    parameter int P     = 0,
    parameter int Q     = 0
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               advance,
    input  logic                               in_valid,
    input  logic                               in_desc,
    input  logic [(1<<LOG_N)-1:0][WIDTH-1:0]   in_data,
    output logic                               out_valid,
    output logic                               out_desc,
    output logic [(1<<LOG_N)-1:0][WIDTH-1:0]   out_data
);

    localparam int unsigned N = 1 << LOG_N;
    localparam int unsigned D = 1 << Q;

    logic [WIDTH-1:0] xchg [0:N-1];

    for (genvar i = 0; i < N; i++) begin : g_pair
        if (((i >> Q) & 1) == 0) begin : g_cmp
            logic [WIDTH-1:0] hi;
            logic [WIDTH-1:0] lo;
            logic             asc;

            max_min #(.WIDTH(WIDTH)) u_cmp (
                .a     (in_data[i]),
                .b     (in_data[i+D]),
                .max_v (hi),
                .min_v (lo)
            );

            // A descending vector flips every pair direction of the network.
            assign asc         = pair_asc(i, P) ^ in_desc;
            assign xchg[i]     = asc ? lo : hi;
            assign xchg[i+D]   = asc ? hi : lo;
        end
    end

    // Stage register: loads on the global advance, holds otherwise.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_desc  <= 1'b0;
            out_data  <= '0;
        end else if (advance) begin
            out_valid <= in_valid;
            out_desc  <= in_desc;
            for (int unsigned i = 0; i < N; i++) begin
                out_data[i] <= xchg[i];
            end
        end
    end

endmodule

// File: rtl/bitonic_sort_pipe.sv
// Fully pipelined bitonic sorter for 2**LOG_N unsigned elements with a
// valid/ready interface, per-vector sort direction and a global stall.
module bitonic_sort_pipe
    import sort_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int LOG_N = 3,
    parameter int N     = 2**LOG_N
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data [0:N-1],
    input  logic             in_desc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data [0:N-1],
    output logic             out_desc,
    output logic             busy
);

    localparam int unsigned S = num_stages(LOG_N);

    // Index 0 is the input port; index k is the register of layer k.
    logic [N-1:0][WIDTH-1:0] stg_data  [0:S];
    logic                    stg_valid [0:S];
    logic                    stg_desc  [0:S];
    logic                    advance;

    // The whole pipe moves together unless the output holds a vector nobody takes.
    assign advance   = !stg_valid[S] || out_ready;
    assign in_ready  = advance;

    assign stg_valid[0] = in_valid;
    assign stg_desc[0]  = in_desc;

    // Repack the input port into the packed stage-0 vector.
    always_comb begin
        for (int unsigned i = 0; i < N; i++) begin
            stg_data[0][i] = in_data[i];
        end
    end

    for (genvar k = 0; k < S; k++) begin : g_layer
        bitonic_layer #(
            .WIDTH (WIDTH),
            .LOG_N (LOG_N),
            .P     (stage_p(k)),
            .Q     (stage_q(k))
        ) u_layer (
            .clk       (clk),
            .rst       (rst),
            .advance   (advance),
            .in_valid  (stg_valid[k]),
            .in_desc   (stg_desc[k]),
            .in_data   (stg_data[k]),
            .out_valid (stg_valid[k+1]),
            .out_desc  (stg_desc[k+1]),
            .out_data  (stg_data[k+1])
        );
    end

    assign out_valid = stg_valid[S];
    assign out_desc  = stg_desc[S];

    // Unpack the last layer onto the output port.
    always_comb begin
        for (int unsigned i = 0; i < N; i++) begin
            out_data[i] = stg_data[S][i];
        end
    end

    // Busy while any layer register holds a vector.
    always_comb begin
        busy = 1'b0;
        for (int unsigned k = 1; k <= S; k++) begin
            busy = busy | stg_valid[k];
        end
    end

endmodule

// File: tb/tb_bitonic_sort_pipe.sv
// Self-checking bench for bitonic_sort_pipe: directed vectors, streaming with
// backpressure, mid-flight reset, and a random sweep over several sizes.
module tb_bitonic_sort_pipe;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data [0:7];
    logic       in_desc;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data [0:7];
    logic       out_desc;
    logic       busy;

    logic       sw_rst = 1'b1;
    logic [5:0] sw_done;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    bitonic_sort_pipe #(.WIDTH(8), .LOG_N(3)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_desc   (in_desc),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_desc  (out_desc),
        .busy      (busy)
    );

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    // Reference: sort the multiset, reverse for descending; 16-bit slot per element.
    function automatic logic [255:0] ref_sort(input int unsigned vals[$], input logic desc);
        int unsigned s[$];
        int unsigned x;
        logic [255:0] r;
        r = '0;
        s = vals;
        if (desc) s.rsort();
        else s.sort();
        for (int i = 0; i < s.size(); i++) begin
            x = s[i];
            r[i*16 +: 16] = x[15:0];
        end
        return r;
    endfunction

    function automatic logic [255:0] pack8(input logic [7:0] a [0:7]);
        logic [255:0] r;
        r = '0;
        for (int i = 0; i < 8; i++) r[i*16 +: 16] = {8'h00, a[i]};
        return r;
    endfunction

    // Scoreboard and protocol monitor for the default instance.
    logic [255:0] exp_q[$];
    logic         exp_d[$];
    int           out_cnt = 0;

    initial begin
        logic         held;
        logic [255:0] held_data;
        logic         held_desc;
        int unsigned  q[$];
        held = 1'b0;
        held_data = '0;
        held_desc = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                exp_q.delete();
                exp_d.delete();
                held = 1'b0;
            end else begin
                check("in_ready_rule", in_ready, !(out_valid && !out_ready));
                if (held) begin
                    check("hold_valid", out_valid, 1'b1);
                    check("hold_data", pack8(out_data), held_data);
                    check("hold_desc", out_desc, held_desc);
                end
                held      = out_valid && !out_ready;
                held_data = pack8(out_data);
                held_desc = out_desc;
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        check("spurious_out", 1'b1, 1'b0);
                    end else begin
                        check("stream_data", pack8(out_data), exp_q.pop_front());
                        check("stream_desc", out_desc, exp_d.pop_front());
                    end
                    out_cnt++;
                end
                if (in_valid && in_ready) begin
                    q.delete();
                    for (int i = 0; i < 8; i++) q.push_back(32'(in_data[i]));
                    exp_q.push_back(ref_sort(q, in_desc));
                    exp_d.push_back(in_desc);
                end
            end
        end
    end

    task automatic run_single(input string tag, input logic [7:0] v [0:7], input logic d,
                              input logic [7:0] e [0:7]);
        int lat;
        @(posedge clk);
        #1;
        for (int i = 0; i < 8; i++) in_data[i] = v[i];
        in_desc  = d;
        in_valid = 1'b1;
        check($sformatf("%s_in_ready", tag), in_ready, 1'b1);
        @(posedge clk);
        #1 in_valid = 1'b0;
        lat = 1;
        @(negedge clk);
        check($sformatf("%s_busy", tag), busy, 1'b1);
        while (!out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check($sformatf("%s_latency", tag), lat, 6);
        check($sformatf("%s_data", tag), pack8(out_data), pack8(e));
        check($sformatf("%s_desc", tag), out_desc, d);
        @(negedge clk);
        check($sformatf("%s_one_cycle", tag), out_valid, 1'b0);
    endtask

    // Parameter sweep: independent instances, out_ready tied high.
    for (genvar c = 0; c < 6; c++) begin : g_sweep
        localparam int LN = (c % 3 == 0) ? 1 : ((c % 3 == 1) ? 2 : 4);
        localparam int W  = (c < 3) ? 4 : 16;
        localparam int NE = 1 << LN;
        localparam int S  = LN * (LN + 1) / 2;

        logic         iv;
        logic         ir;
        logic         idsc;
        logic         ov;
        logic         odsc;
        logic         bsy;
        logic [W-1:0] idat [0:NE-1];
        logic [W-1:0] odat [0:NE-1];
        logic         done = 1'b0;
        logic [255:0] eq[$];
        logic         ed[$];
        int           et[$];
        int           got = 0;

        assign sw_done[c] = done;

        bitonic_sort_pipe #(.WIDTH(W), .LOG_N(LN)) u_dut (
            .clk       (clk),
            .rst       (sw_rst),
            .in_valid  (iv),
            .in_ready  (ir),
            .in_data   (idat),
            .in_desc   (idsc),
            .out_valid (ov),
            .out_ready (1'b1),
            .out_data  (odat),
            .out_desc  (odsc),
            .busy      (bsy)
        );

        function automatic logic [255:0] pk(input logic [W-1:0] a [0:NE-1]);
            logic [255:0] r;
            r = '0;
            for (int i = 0; i < NE; i++) r[i*16 +: 16] = 16'(a[i]);
            return r;
        endfunction

        initial begin
            int unsigned q[$];
            int unsigned base;
            int unsigned x;
            int          mode;
            iv   = 1'b0;
            idsc = 1'b0;
            for (int i = 0; i < NE; i++) idat[i] = '0;
            wait (sw_rst === 1'b0);
            @(posedge clk);
            #1;
            for (int n = 0; n < 1000; n++) begin
                mode = n % 8;
                base = $urandom_range(0, (1 << W) - 1);
                q.delete();
                for (int i = 0; i < NE; i++)
                    q.push_back(mode == 0 ? base : $urandom_range(0, (1 << W) - 1));
                if (mode == 1) q.sort();
                if (mode == 2) q.rsort();
                for (int i = 0; i < NE; i++) begin
                    x = q[i];
                    idat[i] = W'(x);
                end
                idsc = 1'($urandom_range(0, 1));
                iv   = 1'b1;
                @(posedge clk);
                #1;
            end
            iv = 1'b0;
        end

        initial begin
            int unsigned q[$];
            forever begin
                @(negedge clk);
                if (!sw_rst) begin
                    if (ov) begin
                        if (eq.size() == 0) begin
                            check($sformatf("sw%0d_spurious", c), 1'b1, 1'b0);
                        end else begin
                            check($sformatf("sw%0d_data", c), pk(odat), eq.pop_front());
                            check($sformatf("sw%0d_desc", c), odsc, ed.pop_front());
                            check($sformatf("sw%0d_latency", c), cyc - et.pop_front(), S);
                        end
                        got++;
                    end
                    if (iv && ir) begin
                        q.delete();
                        for (int i = 0; i < NE; i++) q.push_back(32'(idat[i]));
                        eq.push_back(ref_sort(q, idsc));
                        ed.push_back(idsc);
                        et.push_back(cyc);
                    end
                end
                done = (got >= 1000);
            end
        end
    end

    initial begin
        sw_rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 sw_rst = 1'b0;
    end

    initial begin
        logic [7:0] sv [0:19][0:7];
        logic       sd [0:19];
        logic [7:0] r3 [0:7];
        int         idx;
        int         sc;
        int         base;
        int         seen;
        logic       acc;

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_desc   = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) in_data[i] = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        @(negedge clk);
        check("reset_out_valid", out_valid, 1'b0);
        check("reset_out_data", pack8(out_data), '0);
        check("reset_out_desc", out_desc, 1'b0);
        check("reset_busy", busy, 1'b0);
        check("reset_in_ready", in_ready, 1'b1);

        run_single("asc",  '{5, 3, 7, 1, 0, 6, 2, 4}, 1'b0, '{0, 1, 2, 3, 4, 5, 6, 7});
        run_single("desc", '{5, 3, 7, 1, 0, 6, 2, 4}, 1'b1, '{7, 6, 5, 4, 3, 2, 1, 0});
        run_single("dups", '{9, 9, 0, 255, 9, 0, 255, 1}, 1'b0, '{0, 0, 1, 9, 9, 9, 255, 255});

        // Streaming: 20 back-to-back vectors, output stalled during cycles 8..12.
        for (int n = 0; n < 20; n++) begin
            for (int i = 0; i < 8; i++) sv[n][i] = 8'($urandom);
            sd[n] = 1'($urandom_range(0, 1));
        end
        base = out_cnt;
        idx  = 0;
        sc   = 0;
        @(posedge clk);
        #1;
        while (idx < 20 && sc < 200) begin
            out_ready = !(sc >= 8 && sc <= 12);
            for (int i = 0; i < 8; i++) in_data[i] = sv[idx][i];
            in_desc  = sd[idx];
            in_valid = 1'b1;
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            if (acc) idx++;
            sc++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        check("stream_all_sent", idx, 20);
        repeat (30) @(posedge clk);
        #1;
        check("stream_count", out_cnt - base, 20);

        // Reset mid-flight: three vectors accepted, then reset discards them.
        base = out_cnt;
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < 8; i++) in_data[i] = 8'($urandom);
            in_valid = 1'b1;
            @(posedge clk);
            #1;
        end
        for (int i = 0; i < 8; i++) in_data[i] = 8'($urandom);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst      = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        check("midrst_busy", busy, 1'b0);
        seen = 0;
        repeat (12) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        check("midrst_no_out", seen, 0);
        check("midrst_no_transfer", out_cnt - base, 0);
        r3 = '{8'd200, 8'd17, 8'd17, 8'd3, 8'd99, 8'd0, 8'd255, 8'd64};
        run_single("after_rst", r3, 1'b0, '{0, 3, 17, 17, 64, 99, 200, 255});

        for (int k = 0; k < 5000 && sw_done != 6'h3f; k++) @(posedge clk);
        check("sweep_done", sw_done, 6'h3f);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/bitonic_sort_pipe.md
Name: bitonic_sort_pipe

Overview:
- Fully pipelined, parametrised bitonic sorter for N = 2**LOG_N unsigned elements of WIDTH bits.
- Accepts one vector per cycle on a valid/ready interface and emits it sorted S = LOG_N*(LOG_N+1)/2 cycles later.
- Sort direction (ascending/descending) is selectable per vector.
- Generalises the existing single-layer compare-exchange step into the complete registered network with backpressure; sits between the sample-capture buffer and downstream top-k/median logic.

Parameters:
- WIDTH, 8, bits per element (unsigned compare).
- LOG_N, 3, log2 of element count; N = 2**LOG_N; legal range 1..6.
- N, 2**LOG_N, derived element count; must not be overridden.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  in_data/in_desc hold a vector.
- in_ready  output  1  block accepts the vector this cycle.
- in_data  input  WIDTH x N (unpacked [0:N-1])  unsorted elements.
- in_desc  input  1  0 = ascending (index 0 smallest), 1 = descending.
- out_valid  output  1  out_data holds a sorted vector.
- out_ready  input  1  downstream accepts the vector.
- out_data  output  WIDTH x N (unpacked [0:N-1])  sorted elements.
- out_desc  output  1  direction flag that travelled with the vector.
- busy  output  1  OR of all stage valid bits.

Behaviour:
- Network: phases p = 0..LOG_N-1; within a phase, layers q = p down to 0. That gives S registered layers in order (0,0), (1,1), (1,0), (2,2), ...
- Layer (p,q), pair selection: pair indices i and i+d, where d = 2**q and bit q of i is 0.
- Layer (p,q), pair direction: ascending pair (min to i, max to i+d) when bit (p+1) of i is 0, otherwise descending. In the final phase every pair is ascending.
- Descending mode: when the vector's desc flag is 1, every pair direction is inverted.
- Ties: when a == b the values pass unchanged. Data is unsigned; there is no sign extension.
- Stage registers: each layer has a data register, a valid bit and a desc bit.
- Global stall: advance = !out_valid | out_ready.
  - On advance, every stage loads from its predecessor; stage 0 loads in_data/in_desc with valid = in_valid.
  - When advance is 0, all stages hold.
  - in_ready = advance, combinational from out_ready and out_valid.
- Handshake: transfer in on in_valid & in_ready; transfer out on out_valid & out_ready. A vector accepted in cycle t appears on out_valid at t+S with no stalls.
- Throughput: one vector per cycle with sustained out_ready = 1.
- Bubbles: invalid stages still advance, so bubbles collapse only through downstream draining. There is no bubble squeezing; this keeps timing simple.
- Output stability: out_data/out_desc stay stable while out_valid = 1 and out_ready = 0.
- Reset:
  - All valid bits clear; all data registers and desc bits go to 0.
  - out_valid = 0, out_data = all 0, out_desc = 0, busy = 0.
  - in_ready = 1 after reset (because out_valid = 0).
- Reset mid-operation: in-flight vectors are discarded and none is emitted afterward. A vector presented in the same cycle as rst is not accepted.
- Simultaneous in-accept and out-accept in the same cycle is legal and is the normal streaming case.
- LOG_N = 1: S = 1, a single compare-exchange plus register.

Decomposition:
- Package sort_pkg holds:
  - function num_stages(log_n), returning log_n*(log_n+1)/2.
  - functions stage_p(k) and stage_q(k), mapping a linear layer index to (p,q).
  - function pair_asc(i, p), the direction bit.
- Sub-module bitonic_layer (params WIDTH, LOG_N, P, Q):
  - Combinational compare-exchange of all N/2 pairs, with the desc input applied.
  - Output register, valid/desc registers and the advance enable.
  - Instantiated S times by a generate loop in bitonic_sort_pipe.
- bitonic_layer reuses the existing max_min comparator.

Test Plan:
- Reset then idle: hold rst 2 cycles -> out_valid = 0, out_data all 0, busy = 0, in_ready = 1.
- Single vector (defaults), ascending: in_data {5,3,7,1,0,6,2,4}, in_desc = 0 -> after exactly 6 cycles out_data {0,1,2,3,4,5,6,7}, out_desc = 0, single-cycle out_valid.
- Same vector with in_desc = 1 -> {7,6,5,4,3,2,1,0}. Duplicates {9,9,0,255,9,0,255,1} ascending -> {0,0,1,9,9,9,255,255}.
- Streaming with backpressure:
  - Stimulus: 20 random vectors back-to-back, mixed direction; out_ready low for cycles 8–12.
  - Required response: no loss or reorder; output stable while stalled; in_ready low exactly when out_valid & !out_ready; matches reference model.
- Reset mid-flight: 3 vectors accepted, rst at cycle 3 -> nothing emitted afterward; the next vector sorts correctly with latency 6.
- Parameter sweep LOG_N = 1, 2, 4 at WIDTH = 4 and 16:
  - 1000 random vectors each, including all-equal and already-sorted/reverse inputs.
  - Latency = S (1, 3, 10) and results match the model.
